// File: rtl/counter_cfg_sequencer.sv
// Bus-master front end for the up/down counter: writes PLR/ULR/LLR/CCR, verifies them by readback,
// fires one start pulse, waits for ec and reports status plus run length.
module counter_cfg_sequencer #(
  parameter int WR_PULSE = 2,
  parameter int SETTLE   = 2,
  parameter int TIMEOUT  = 4096,
  parameter int RUN_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [7:0]       cfg_plr,
  input  logic [7:0]       cfg_ulr,
  input  logic [7:0]       cfg_llr,
  input  logic [7:0]       cfg_ccr,
  output logic [7:0]       bus_dout,
  output logic             bus_oe,
  input  logic [7:0]       bus_din,
  output logic             ncs,
  output logic             nwr,
  output logic             nrd,
  output logic             a1,
  output logic             a0,
  output logic             start,
  input  logic             ec,
  input  logic             err,
  output logic             done,
  output logic [1:0]       status,
  output logic [RUN_W-1:0] run_cycles
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRECHK = 3'd1;
  localparam logic [2:0] S_WR     = 3'd2;
  localparam logic [2:0] S_RD     = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_START  = 3'd5;
  localparam logic [2:0] S_WAIT   = 3'd6;
  localparam logic [2:0] S_FIN    = 3'd7;

  localparam int CNT_W = $clog2(TIMEOUT + WR_PULSE + SETTLE + 2);
  localparam logic [CNT_W-1:0] PH_STRB = CNT_W'(WR_PULSE);
  localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(WR_PULSE + 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic [3:0][7:0]      cfg_q, cfg_d;
  logic [1:0]           status_q, status_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic                 ncs_q, ncs_d, nwr_q, nwr_d, nrd_q, nrd_d;
  logic                 oe_q, oe_d, start_q, start_d, done_q, done_d, ready_q, ready_d;
  logic [7:0]           dout_q, dout_d;
  logic [1:0]           addr_q, addr_d;

  // Sequencer next-state: access phases counted by cnt, register index by idx.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    cfg_d    = cfg_q;
    status_d = status_q;
    run_d    = run_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid && ready_q) begin
          state_d  = S_PRECHK;
          cfg_d    = {cfg_ccr, cfg_llr, cfg_ulr, cfg_plr};
          status_d = 2'b00;
          run_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRECHK: begin
        cnt_d = '0;
        idx_d = 2'd0;
        if ((cfg_q[0] < cfg_q[2]) || (cfg_q[0] > cfg_q[1])) begin
          state_d  = S_FIN;
          status_d = 2'b10;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (cnt_q == PH_LAST) begin
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d = S_RD;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD: begin
        // A locked counter ignores writes, so a stale readback shows up here.
        if ((cnt_q == PH_STRB) && (bus_din != cfg_q[idx_q])) begin
          state_d  = S_FIN;
          status_d = 2'b01;
        end else if (cnt_q == PH_LAST) begin
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d = S_SETTLE;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == ST_LAST) begin
          cnt_d = '0;
          if (err) begin
            state_d  = S_FIN;
            status_d = 2'b10;
          end else begin
            state_d = S_START;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (ec) begin
          state_d  = S_FIN;
          status_d = 2'b00;
        end else begin
          run_d = (&run_q) ? run_q : run_q + RUN_W'(1);
          if (cnt_q == TO_LAST) begin
            state_d  = S_FIN;
            status_d = 2'b11;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every bus pin comes straight from a flop.
  always_comb begin
    ncs_d   = 1'b1;
    nwr_d   = 1'b1;
    nrd_d   = 1'b1;
    oe_d    = 1'b0;
    dout_d  = 8'h00;
    addr_d  = 2'b00;
    start_d = (state_d == S_START);
    done_d  = (state_d == S_FIN);
    ready_d = (state_d == S_IDLE);
    case (state_d)
      S_WR: begin
        ncs_d  = 1'b0;
        addr_d = idx_d;
        dout_d = cfg_d[idx_d];
        oe_d   = (cnt_d != PH_LAST);
        nwr_d  = (cnt_d == '0) || (cnt_d == PH_LAST);
      end
      S_RD: begin
        ncs_d  = 1'b0;
        addr_d = idx_d;
        nrd_d  = (cnt_d == '0) || (cnt_d == PH_LAST);
      end
      S_SETTLE, S_START, S_WAIT: ncs_d = 1'b0;
      default: ncs_d = 1'b1;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      cfg_q    <= '0;
      status_q <= 2'b00;
      run_q    <= '0;
      ncs_q    <= 1'b1;
      nwr_q    <= 1'b1;
      nrd_q    <= 1'b1;
      oe_q     <= 1'b0;
      dout_q   <= 8'h00;
      addr_q   <= 2'b00;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      cfg_q    <= cfg_d;
      status_q <= status_d;
      run_q    <= run_d;
      ncs_q    <= ncs_d;
      nwr_q    <= nwr_d;
      nrd_q    <= nrd_d;
      oe_q     <= oe_d;
      dout_q   <= dout_d;
      addr_q   <= addr_d;
      start_q  <= start_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign cfg_ready  = ready_q;
  assign bus_dout   = dout_q;
  assign bus_oe     = oe_q;
  assign ncs        = ncs_q;
  assign nwr        = nwr_q;
  assign nrd        = nrd_q;
  assign a1         = addr_q[1];
  assign a0         = addr_q[0];
  assign start      = start_q;
  assign done       = done_q;
  assign status     = status_q;
  assign run_cycles = run_q;

endmodule

// File: tb/tb_counter_cfg_sequencer.sv
// Directed bench for counter_cfg_sequencer with a small behavioural model of the counter's
// register bus, write lock and end-cycle flag.
module tb_counter_cfg_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_plr = 8'd0, cfg_ulr = 8'd0, cfg_llr = 8'd0, cfg_ccr = 8'd0;
  logic        cfg_ready, bus_oe, ncs, nwr, nrd, a1, a0, start, done;
  logic [7:0]  bus_dout, bus_din;
  logic [1:0]  status;
  logic [15:0] run_cycles;
  logic        ec = 1'b0;
  logic        err_in = 1'b0;

  logic [7:0]  regs [4];
  logic        locked = 1'b0, busy = 1'b0, unlock = 1'b1, ec_en = 1'b1;
  logic [7:0]  cd = 8'd0;
  logic        mon_clr = 1'b1;
  int          wr_lo, rd_lo, ovl, st_cnt, ncs_lo, done_cnt;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  counter_cfg_sequencer #(.WR_PULSE(2), .SETTLE(2), .TIMEOUT(64), .RUN_W(16)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_plr(cfg_plr), .cfg_ulr(cfg_ulr), .cfg_llr(cfg_llr), .cfg_ccr(cfg_ccr),
    .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din),
    .ncs(ncs), .nwr(nwr), .nrd(nrd), .a1(a1), .a0(a0), .start(start),
    .ec(ec), .err(err_in), .done(done), .status(status), .run_cycles(run_cycles)
  );

  assign bus_din = (!ncs && !nrd) ? regs[{a1, a0}] : 8'h00;

  // Counter model: writes blocked while locked; start locks and loads ccr; ec fires when it runs out.
  always @(posedge clk) begin
    if (unlock) begin
      locked <= 1'b0;
      busy   <= 1'b0;
      ec     <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else begin
      if (!ncs && !nwr && !locked) regs[{a1, a0}] <= bus_dout;
      if (start) begin
        busy <= 1'b1; cd <= regs[3]; locked <= 1'b1; ec <= 1'b0;
      end else if (busy && cd == 8'd0) begin
        if (ec_en) begin
          ec <= 1'b1; busy <= 1'b0; locked <= 1'b0;
        end else begin
          ec <= 1'b0;
        end
      end else begin
        if (busy) cd <= cd - 8'd1;
        ec <= 1'b0;
      end
    end
  end

  // Bus activity monitor.
  always @(posedge clk) begin
    if (mon_clr) begin
      wr_lo <= 0; rd_lo <= 0; ovl <= 0; st_cnt <= 0; ncs_lo <= 0; done_cnt <= 0;
    end else begin
      if (!ncs && !nwr) wr_lo <= wr_lo + 1;
      if (!ncs && !nrd) rd_lo <= rd_lo + 1;
      if (!nwr && !nrd) ovl <= ovl + 1;
      if (start) st_cnt <= st_cnt + 1;
      if (!ncs) ncs_lo <= ncs_lo + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic clr_mon;
    @(negedge clk) mon_clr = 1'b1;
    @(negedge clk) mon_clr = 1'b0;
  endtask

  // Presents a config at a negedge where cfg_ready is high; returns #1 after the accepting edge.
  task automatic present(input logic [7:0] p, u, l, c, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    cfg_plr = p; cfg_ulr = u; cfg_llr = l; cfg_ccr = c;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < max) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ncs, nwr, nrd, bus_oe, start, done, a1, a0, cfg_ready} !== 9'b111_0000_01 ||
        bus_dout !== 8'h00 || status !== 2'b00 || run_cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got ncs/nwr/nrd/oe/start/done/a1/a0/rdy=%b dout=%h st=%b run=%0d, want 111000001 00 00 0",
               {ncs, nwr, nrd, bus_oe, start, done, a1, a0, cfg_ready}, bus_dout, status, run_cycles);
    end
    @(negedge clk);
    reset = 1'b1;
    unlock = 1'b0;
  endtask

  task automatic test_basic;
    int cyc;
    bit got;
    logic [7:0] exp_r [4];
    exp_r[0] = 8'd5; exp_r[1] = 8'd8; exp_r[2] = 8'd3; exp_r[3] = 8'd1;
    clr_mon();
    present(8'd5, 8'd8, 8'd3, 8'd1, 1'b0);
    wait_done(200, cyc, got);
    checks++;
    if (!got || cyc !== 39) begin
      errors++; $display("FAIL basic_latency: got=%0d cycles=%0d, want done after 39", got, cyc);
    end
    checks++;
    if (status !== 2'b00 || run_cycles !== 16'd2) begin
      errors++; $display("FAIL basic_status: status=%b run=%0d, want 00 run=2", status, run_cycles);
    end
    checks++;
    if (wr_lo !== 8 || rd_lo !== 8 || ovl !== 0 || st_cnt !== 1) begin
      errors++; $display("FAIL basic_strobes: wr=%0d rd=%0d overlap=%0d start=%0d, want 8 8 0 1", wr_lo, rd_lo, ovl, st_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (regs[i] !== exp_r[i]) begin
        errors++; $display("FAIL basic_reg%0d: got %0d want %0d", i, regs[i], exp_r[i]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || status !== 2'b00 || run_cycles !== 16'd2 || cfg_ready !== 1'b1 || ncs !== 1'b1) begin
      errors++; $display("FAIL basic_hold: done=%b st=%b run=%0d rdy=%b ncs=%b, want 0 00 2 1 1", done, status, run_cycles, cfg_ready, ncs);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit got;
    clr_mon();
    present(8'd4, 8'd6, 8'd4, 8'd1, 1'b1);
    wait_done(200, cyc, got);
    checks++;
    if (!got || cyc !== 39 || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got=%0d cycles=%0d rdy=%b, want 39 rdy 0", got, cyc, cfg_ready);
    end
    wait_done(200, cyc, got);
    #0 cfg_valid = 1'b0;
    checks++;
    if (!got || cyc !== 41 || status !== 2'b00 || st_cnt !== 2) begin
      errors++; $display("FAIL b2b_second: got=%0d cycles=%0d status=%b starts=%0d, want 41 00 2", got, cyc, status, st_cnt);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== 2 || cfg_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_count: dones=%0d rdy=%b, want 2 1", done_cnt, cfg_ready);
    end
  endtask

  task automatic test_range_err;
    int cyc;
    bit got;
    clr_mon();
    present(8'd9, 8'd8, 8'd3, 8'd0, 1'b0);
    wait_done(50, cyc, got);
    checks++;
    if (!got || cyc !== 1 || status !== 2'b10 || run_cycles !== 16'd0) begin
      errors++; $display("FAIL range_high: got=%0d cycles=%0d status=%b run=%0d, want 1 10 0", got, cyc, status, run_cycles);
    end
    present(8'd2, 8'd8, 8'd3, 8'd0, 1'b0);
    wait_done(50, cyc, got);
    checks++;
    if (!got || cyc !== 1 || status !== 2'b10) begin
      errors++; $display("FAIL range_low: got=%0d cycles=%0d status=%b, want 1 10", got, cyc, status);
    end
    checks++;
    if (ncs_lo !== 0 || wr_lo !== 0) begin
      errors++; $display("FAIL range_ncs: ncs low cycles=%0d writes=%0d, want 0 0", ncs_lo, wr_lo);
    end
  endtask

  task automatic test_settle_err;
    int cyc;
    bit got;
    clr_mon();
    err_in = 1'b1;
    present(8'd5, 8'd8, 8'd3, 8'd1, 1'b0);
    wait_done(200, cyc, got);
    err_in = 1'b0;
    checks++;
    if (!got || cyc !== 35 || status !== 2'b10 || st_cnt !== 0) begin
      errors++; $display("FAIL settle_err: got=%0d cycles=%0d status=%b starts=%0d, want 35 10 0", got, cyc, status, st_cnt);
    end
  endtask

  task automatic test_timeout;
    int cyc;
    bit got;
    clr_mon();
    ec_en = 1'b0;
    present(8'd4, 8'd9, 8'd2, 8'd7, 1'b0);
    wait_done(300, cyc, got);
    checks++;
    if (!got || cyc !== 100 || status !== 2'b11 || run_cycles !== 16'd64) begin
      errors++; $display("FAIL timeout: got=%0d cycles=%0d status=%b run=%0d, want 100 11 64", got, cyc, status, run_cycles);
    end
    checks++;
    if (ncs !== 1'b1 || st_cnt !== 1) begin
      errors++; $display("FAIL timeout_ncs: ncs=%b starts=%0d, want 1 1", ncs, st_cnt);
    end
  endtask

  task automatic test_write_lock;
    int cyc;
    bit got;
    clr_mon();
    present(8'd6, 8'd9, 8'd2, 8'd3, 1'b0);
    wait_done(200, cyc, got);
    checks++;
    if (!got || cyc !== 20 || status !== 2'b01 || st_cnt !== 0) begin
      errors++; $display("FAIL write_lock: got=%0d cycles=%0d status=%b starts=%0d, want 20 01 0", got, cyc, status, st_cnt);
    end
    checks++;
    if (regs[0] !== 8'd4 || ncs !== 1'b1) begin
      errors++; $display("FAIL write_lock_reg: plr=%0d ncs=%b, want 4 1", regs[0], ncs);
    end
    @(negedge clk) unlock = 1'b1;
    @(negedge clk) unlock = 1'b0;
    ec_en = 1'b1;
  endtask

  task automatic test_ccr_zero;
    int cyc;
    bit got;
    clr_mon();
    present(8'd3, 8'd8, 8'd3, 8'd0, 1'b0);
    wait_done(200, cyc, got);
    checks++;
    if (!got || cyc !== 38 || status !== 2'b00 || run_cycles > 16'd1) begin
      errors++; $display("FAIL ccr0_llr_edge: got=%0d cycles=%0d status=%b run=%0d, want 38 00 <=1", got, cyc, status, run_cycles);
    end
    present(8'd8, 8'd8, 8'd3, 8'd0, 1'b0);
    wait_done(200, cyc, got);
    checks++;
    if (!got || cyc !== 38 || status !== 2'b00 || run_cycles !== 16'd1) begin
      errors++; $display("FAIL ccr0_ulr_edge: got=%0d cycles=%0d status=%b run=%0d, want 38 00 1", got, cyc, status, run_cycles);
    end
  endtask

  task automatic test_reset_mid;
    present(8'd5, 8'd8, 8'd3, 8'd1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (nwr !== 1'b0 || {a1, a0} !== 2'b10 || bus_oe !== 1'b1 || bus_dout !== 8'd3) begin
      errors++; $display("FAIL mid_wr2: nwr=%b addr=%b oe=%b dout=%0d, want 0 10 1 3", nwr, {a1, a0}, bus_oe, bus_dout);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({ncs, nwr, nrd, bus_oe, done, start, cfg_ready} !== 7'b1110001 || status !== 2'b00) begin
      errors++; $display("FAIL mid_reset: ncs/nwr/nrd/oe/done/start/rdy=%b status=%b, want 1110001 00",
                         {ncs, nwr, nrd, bus_oe, done, start, cfg_ready}, status);
    end
    reset = 1'b1;
    clr_mon();
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== 0 || ncs_lo !== 0) begin
      errors++; $display("FAIL mid_no_done: dones=%0d ncs low=%0d, want 0 0", done_cnt, ncs_lo);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_range_err();
    test_settle_err();
    test_timeout();
    test_write_lock();
    test_ccr_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
